// File: rtl/gmii_rx_unpack48_if.sv
// GMII receive pins and FIFO write side of the payload unpacker.
// The master drives the line and reads the FIFO port; the slave is the unpacker.
interface gmii_rx_unpack48_if;
    logic [7:0]  rxd;
    logic        rx_dv;
    logic        rx_er;
    logic        fifo_full;
    logic [47:0] din;
    logic        wr_en;

    modport master (
        output rxd, rx_dv, rx_er, fifo_full,
        input  din, wr_en
    );

    modport slave (
        input  rxd, rx_dv, rx_er, fifo_full,
        output din, wr_en
    );
endinterface

// File: rtl/gmii_rx_unpack48.sv
// GMII frame filter: strips preamble/headers and packs payload into 48-bit
// FIFO words, counting accepted, dropped and overflowed traffic.
module gmii_rx_unpack48 #(
    parameter logic [47:0] MAC_ADDR  = 48'h00_0A_35_00_00_01,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int          MAX_WORDS = 250
) (
    input  logic               rx_clk,
    input  logic               sys_rst_n,
    gmii_rx_unpack48_if.slave  bus,
    output logic [15:0]        frame_cnt,
    output logic [15:0]        drop_cnt,
    output logic [15:0]        ovf_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_HDR, S_LEN, S_PAY, S_DRAIN
    } state_t;

    state_t      state, state_d;
    logic [3:0]  idx, idx_d;
    logic [7:0]  wcnt, wcnt_d;
    logic [7:0]  len, len_d;
    logic [47:0] pack, pack_d;
    logic [47:0] din_q, din_d;
    logic        wr_q, wr_d;
    logic        frame_inc, drop_inc, ovf_inc;
    logic [47:0] shifted;

    assign shifted = {pack[39:0], bus.rxd};
    assign bus.din = din_q;
    assign bus.wr_en = wr_q;

    always_ff @(posedge rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            wcnt      <= '0;
            len       <= '0;
            pack      <= '0;
            din_q     <= '0;
            wr_q      <= 1'b0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
            ovf_cnt   <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            wcnt  <= wcnt_d;
            len   <= len_d;
            pack  <= pack_d;
            din_q <= din_d;
            wr_q  <= wr_d;
            if (frame_inc) frame_cnt <= frame_cnt + 16'd1;
            if (drop_inc)  drop_cnt  <= drop_cnt + 16'd1;
            if (ovf_inc)   ovf_cnt   <= ovf_cnt + 16'd1;
        end
    end

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        wcnt_d    = wcnt;
        len_d     = len;
        pack_d    = pack;
        din_d     = din_q;
        wr_d      = 1'b0;
        frame_inc = 1'b0;
        drop_inc  = 1'b0;
        ovf_inc   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.rx_dv)
                    state_d = (bus.rxd == 8'h55) ? S_PRE : S_DRAIN;
            end
            S_PRE: begin
                if (!bus.rx_dv) begin
                    state_d = S_IDLE;
                end else if (bus.rxd == 8'hD5) begin
                    state_d = S_HDR;
                    idx_d   = '0;
                end else if (bus.rxd != 8'h55) begin
                    state_d = S_DRAIN;
                end
            end
            S_HDR, S_LEN, S_PAY: begin
                // Aborts drop any partially packed word with the frame.
                if (!bus.rx_dv) begin
                    state_d  = S_IDLE;
                    drop_inc = 1'b1;
                end else if (bus.rx_er) begin
                    state_d  = S_DRAIN;
                    drop_inc = 1'b1;
                end else begin
                    pack_d = shifted;
                    idx_d  = idx + 4'd1;
                    if (state == S_HDR) begin
                        if (idx == 4'd5 && shifted != MAC_ADDR &&
                            shifted != 48'hFFFF_FFFF_FFFF) begin
                            state_d  = S_DRAIN;
                            drop_inc = 1'b1;
                        end else if (idx == 4'd13) begin
                            if (shifted[15:0] != ETHERTYPE) begin
                                state_d  = S_DRAIN;
                                drop_inc = 1'b1;
                            end else begin
                                state_d = S_LEN;
                                idx_d   = '0;
                            end
                        end
                    end else if (state == S_LEN) begin
                        if (idx == 4'd1) begin
                            if (shifted[15:0] == 16'd0 ||
                                shifted[15:0] > 16'(MAX_WORDS)) begin
                                state_d  = S_DRAIN;
                                drop_inc = 1'b1;
                            end else begin
                                state_d = S_PAY;
                                idx_d   = '0;
                                wcnt_d  = '0;
                                len_d   = shifted[7:0];
                            end
                        end
                    end else if (idx == 4'd5) begin
                        idx_d   = '0;
                        din_d   = shifted;
                        wr_d    = !bus.fifo_full;
                        ovf_inc = bus.fifo_full;
                        wcnt_d  = wcnt + 8'd1;
                        if (wcnt + 8'd1 == len) begin
                            state_d   = S_DRAIN;
                            frame_inc = 1'b1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (!bus.rx_dv) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gmii_rx_unpack48.sv
// Directed bench for gmii_rx_unpack48: frames built byte by byte, expected
// FIFO words queued as each sixth payload byte is driven.
module tb_gmii_rx_unpack48;

    localparam logic [47:0] MAC   = 48'h00_0A_35_00_00_01;
    localparam logic [47:0] OTHER = 48'h00_0A_35_00_00_02;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] ET    = 16'h88B5;

    logic        rx_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [15:0] frame_cnt, drop_cnt, ovf_cnt;

    gmii_rx_unpack48_if bus();

    gmii_rx_unpack48 dut (
        .rx_clk    (rx_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt),
        .ovf_cnt   (ovf_cnt)
    );

    always #4 rx_clk = ~rx_clk;

    int errors = 0;
    int checks = 0;
    logic [47:0] sb[$];
    logic [15:0] e_frame = 0, e_drop = 0, e_ovf = 0;

    task automatic chk(string tag, logic [47:0] obs, logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rx_clk cycle: drive at negedge, check wr_en/din just after posedge.
    task automatic step(logic dv, logic [7:0] b, logic er, logic ff,
                        bit exp_wr, string tag);
        @(negedge rx_clk);
        bus.rx_dv = dv;
        bus.rxd = b;
        bus.rx_er = er;
        bus.fifo_full = ff;
        @(posedge rx_clk);
        #1;
        chk({tag, "_wr_en"}, 48'(bus.wr_en), 48'(exp_wr));
        if (bus.wr_en) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL %s_unexpected_write observed=%h expected=none",
                       tag, bus.din);
            end
            if (sb.size() != 0) chk({tag, "_din"}, bus.din, sb.pop_front());
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "idle");
    endtask

    task automatic check_counters(string tag);
        chk({tag, "_frame_cnt"}, 48'(frame_cnt), 48'(e_frame));
        chk({tag, "_drop_cnt"}, 48'(drop_cnt), 48'(e_drop));
        chk({tag, "_ovf_cnt"}, 48'(ovf_cnt), 48'(e_ovf));
    endtask

    task automatic pulse_reset(string tag);
        sys_rst_n = 1'b0;
        #1;
        chk({tag, "_rst_din"}, bus.din, 48'd0);
        chk({tag, "_rst_wr_en"}, 48'(bus.wr_en), 48'd0);
        chk({tag, "_rst_frame"}, 48'(frame_cnt), 48'd0);
        chk({tag, "_rst_drop"}, 48'(drop_cnt), 48'd0);
        chk({tag, "_rst_ovf"}, 48'(ovf_cnt), 48'd0);
        sb.delete();
        e_frame = 0;
        e_drop = 0;
        e_ovf = 0;
        @(negedge rx_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic send_frame(string tag, logic [47:0] dst, logic [15:0] et,
                              logic [15:0] n, int npay, int er_at,
                              int full_word, int rst_at, logic [7:0] base);
        logic [7:0]  hdr[16];
        logic [7:0]  b;
        logic [47:0] w;
        bit ok, dead, er, ff, wr;
        w = '0;
        ok = (dst == MAC || dst == BCAST) && et == ET &&
             n != 16'd0 && n <= 16'd250;
        dead = !ok;
        for (int i = 0; i < 7; i++) step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, {tag, "_pre"});
        step(1'b1, 8'hD5, 1'b0, 1'b0, 1'b0, {tag, "_sfd"});
        for (int i = 0; i < 6; i++) hdr[i] = dst[47-8*i -: 8];
        for (int i = 6; i < 12; i++) hdr[i] = 8'hA0 + 8'(i);
        hdr[12] = et[15:8];
        hdr[13] = et[7:0];
        hdr[14] = n[15:8];
        hdr[15] = n[7:0];
        for (int i = 0; i < 16; i++) step(1'b1, hdr[i], 1'b0, 1'b0, 1'b0, {tag, "_hdr"});
        for (int i = 0; i < npay; i++) begin
            b  = base + 8'(i);
            er = (i == er_at);
            ff = ((i / 6) == full_word);
            w  = {w[39:0], b};
            if (er) dead = 1'b1;
            wr = !dead && (i % 6 == 5) && (i / 6 < int'(n)) && !ff;
            if (wr) sb.push_back(w);
            step(1'b1, b, er, ff, wr, {tag, "_pay"});
            if (i == rst_at) begin
                pulse_reset(tag);
                dead = 1'b1;
            end
        end
        if (npay >= int'(n) * 6 || (er_at >= 0 && er_at < npay)) begin
            step(1'b1, 8'hDE, 1'b0, 1'b0, 1'b0, {tag, "_fcs"});
            step(1'b1, 8'hAD, 1'b0, 1'b0, 1'b0, {tag, "_fcs"});
            step(1'b1, 8'hBE, 1'b0, 1'b0, 1'b0, {tag, "_fcs"});
            step(1'b1, 8'hEF, 1'b0, 1'b0, 1'b0, {tag, "_fcs"});
        end
        idle(3);
        if (rst_at >= 0 && rst_at < npay) begin
        end else if (!ok) begin
            e_drop++;
        end else if (er_at >= 0 && er_at < npay) begin
            e_drop++;
        end else if (npay < int'(n) * 6) begin
            e_drop++;
        end else begin
            e_frame++;
            if (full_word >= 0 && full_word < int'(n)) e_ovf++;
        end
        check_counters(tag);
    endtask

    initial begin
        bus.rxd = 8'h00;
        bus.rx_dv = 1'b0;
        bus.rx_er = 1'b0;
        bus.fifo_full = 1'b0;
        repeat (2) @(posedge rx_clk);
        #1;
        chk("reset_din", bus.din, 48'd0);
        chk("reset_wr_en", 48'(bus.wr_en), 48'd0);
        check_counters("reset");
        @(negedge rx_clk);
        sys_rst_n = 1'b1;
        idle(2);

        send_frame("t1_good", MAC, ET, 16'd2, 12, -1, -1, -1, 8'h01);
        send_frame("t2_wrong_dst", OTHER, ET, 16'd2, 12, -1, -1, -1, 8'h01);
        send_frame("t2_bcast", BCAST, ET, 16'd2, 12, -1, -1, -1, 8'h21);
        send_frame("t3_etype", MAC, 16'h0800, 16'd2, 12, -1, -1, -1, 8'h01);
        send_frame("t3_n0", MAC, ET, 16'd0, 12, -1, -1, -1, 8'h01);
        send_frame("t3_n251", MAC, ET, 16'd251, 12, -1, -1, -1, 8'h01);
        send_frame("t3_n250", MAC, ET, 16'd250, 1500, -1, -1, -1, 8'h10);
        send_frame("t4_ovf", MAC, ET, 16'd3, 18, -1, 1, -1, 8'h31);
        send_frame("t5_rx_er", MAC, ET, 16'd4, 24, 8, -1, -1, 8'h41);
        send_frame("t5_trunc", MAC, ET, 16'd4, 8, -1, -1, -1, 8'h61);
        send_frame("t6_reset", MAC, ET, 16'd2, 12, -1, -1, 8, 8'h71);
        idle(5);
        send_frame("t6_after", MAC, ET, 16'd2, 12, -1, -1, -1, 8'h81);
        chk("t6_after_frame_is_one", 48'(frame_cnt), 48'd1);

        chk("sb_drained", 48'(sb.size()), 48'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
